// File: rtl/traffic_pkg.sv
// Shared types for the intersection light blocks: FSM state encoding, lamp bundle and
// the three legal single-head lamp patterns.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_CLR_A = 3'd0,
    ST_NS_G  = 3'd1,
    ST_NS_Y  = 3'd2,
    ST_CLR_B = 3'd3,
    ST_EW_G  = 3'd4,
    ST_EW_Y  = 3'd5,
    ST_WALK  = 3'd6
  } xing_state_t;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_t;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;

  localparam lamp_t LAMP_RED = 3'b100;
  localparam lamp_t LAMP_YEL = 3'b010;
  localparam lamp_t LAMP_GRN = 3'b001;

  function automatic logic lamp_legal(input lamp_t l);
    return (l == LAMP_RED) || (l == LAMP_YEL) || (l == LAMP_GRN);
  endfunction

endpackage

// File: rtl/intersection_controller_if.sv
// Pedestrian request plus lamp-driver outputs of the intersection controller.
interface intersection_controller_if;
  logic ped_req;
  logic ns_red;
  logic ns_yellow;
  logic ns_green;
  logic ew_red;
  logic ew_yellow;
  logic ew_green;
  logic walk;
  logic ped_pend;

  modport master (
    output ped_req,
    input  ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_pend
  );

  modport slave (
    input  ped_req,
    output ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_pend
  );
endinterface

// File: rtl/dwell_timer.sv
// Phase dwell counter: counts 0..dur-1, flags the last cycle, clears on restart.
module dwell_timer #(
  parameter int TW = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [TW:0] dur,
  input  logic        restart,
  output logic        done
);

  logic [TW-1:0] count_r;

  // dwell count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {TW{1'b0}};
    end else if (restart) begin
      count_r <= {TW{1'b0}};
    end else begin
      count_r <= count_r + TW'(1);
    end
  end

  assign done = ({1'b0, count_r} == (dur - (TW+1)'(1)));

endmodule

// File: rtl/intersection_controller_chk.sv
// Lamp safety invariants: no conflicting go-signals, walk only under all-red, one-hot heads.
module intersection_controller_chk
  import traffic_pkg::*;
(
  input logic  clk,
  input logic  rst_n,
  input lamp_t ns_lamp,
  input lamp_t ew_lamp,
  input logic  walk
);

  a_no_conflict: assert property (@(posedge clk) disable iff (!rst_n)
    !((ns_lamp.green | ns_lamp.yellow) && (ew_lamp.green | ew_lamp.yellow)));

  a_walk_all_red: assert property (@(posedge clk) disable iff (!rst_n)
    walk |-> (ns_lamp.red && ew_lamp.red));

  a_heads_legal: assert property (@(posedge clk) disable iff (!rst_n)
    lamp_legal(ns_lamp) && lamp_legal(ew_lamp));

endmodule

// File: rtl/intersection_controller.sv
// Two-way intersection sequencer with all-red clearances and a latched pedestrian WALK phase.
// Lamp outputs are Moore-decoded from the state register.
module intersection_controller
  import traffic_pkg::*;
#(
  parameter int GREEN_CYC  = 15,
  parameter int YELLOW_CYC = 5,
  parameter int CLR_CYC    = 2,
  parameter int WALK_CYC   = 10,
  parameter int TW         = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  intersection_controller_if.slave bus
);

  xing_state_t state_r, next_s;
  dir_t        ret_dir_r;
  logic        ped_pend_r;
  logic [TW:0] dur_s;
  logic        done_s;
  logic        restart_s;
  lamp_t       ns_lamp_s, ew_lamp_s;
  logic        walk_s;

  // dwell length of the current phase
  always_comb begin
    dur_s = (TW+1)'(CLR_CYC);
    case (state_r)
      ST_NS_G, ST_EW_G: dur_s = (TW+1)'(GREEN_CYC);
      ST_NS_Y, ST_EW_Y: dur_s = (TW+1)'(YELLOW_CYC);
      ST_WALK:          dur_s = (TW+1)'(WALK_CYC);
      default:          dur_s = (TW+1)'(CLR_CYC);
    endcase
  end

  dwell_timer #(.TW(TW)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .dur     (dur_s),
    .restart (restart_s),
    .done    (done_s)
  );

  // next-state selection; an unencoded state falls back to CLR_A
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_CLR_A: if (done_s) next_s = ped_pend_r ? ST_WALK : ST_NS_G; else next_s = state_r;
      ST_NS_G:  if (done_s) next_s = ST_NS_Y;  else next_s = state_r;
      ST_NS_Y:  if (done_s) next_s = ST_CLR_B; else next_s = state_r;
      ST_CLR_B: if (done_s) next_s = ped_pend_r ? ST_WALK : ST_EW_G; else next_s = state_r;
      ST_EW_G:  if (done_s) next_s = ST_EW_Y;  else next_s = state_r;
      ST_EW_Y:  if (done_s) next_s = ST_CLR_A; else next_s = state_r;
      ST_WALK:  if (done_s) next_s = (ret_dir_r == DIR_EW) ? ST_EW_G : ST_NS_G;
                else next_s = state_r;
      default:  next_s = ST_CLR_A;
    endcase
    restart_s = done_s || (next_s != state_r);
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_CLR_A;
    end else begin
      state_r <= next_s;
    end
  end

  // direction the pending clearance was heading to, used to resume after WALK
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_dir_r <= DIR_NS;
    end else if (state_r == ST_CLR_A && done_s) begin
      ret_dir_r <= DIR_NS;
    end else if (state_r == ST_CLR_B && done_s) begin
      ret_dir_r <= DIR_EW;
    end else begin
      ret_dir_r <= ret_dir_r;
    end
  end

  // pedestrian latch: entry into WALK clears it and wins over a new request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_pend_r <= 1'b0;
    end else if (next_s == ST_WALK && state_r != ST_WALK) begin
      ped_pend_r <= 1'b0;
    end else if (bus.ped_req && state_r != ST_WALK) begin
      ped_pend_r <= 1'b1;
    end else begin
      ped_pend_r <= ped_pend_r;
    end
  end

  // lamp decode from the state register
  always_comb begin
    ns_lamp_s = LAMP_RED;
    ew_lamp_s = LAMP_RED;
    walk_s    = 1'b0;
    case (state_r)
      ST_NS_G: ns_lamp_s = LAMP_GRN;
      ST_NS_Y: ns_lamp_s = LAMP_YEL;
      ST_EW_G: ew_lamp_s = LAMP_GRN;
      ST_EW_Y: ew_lamp_s = LAMP_YEL;
      ST_WALK: walk_s    = 1'b1;
      default: begin
        ns_lamp_s = LAMP_RED;
        ew_lamp_s = LAMP_RED;
        walk_s    = 1'b0;
      end
    endcase
  end

  assign bus.ns_red    = ns_lamp_s.red;
  assign bus.ns_yellow = ns_lamp_s.yellow;
  assign bus.ns_green  = ns_lamp_s.green;
  assign bus.ew_red    = ew_lamp_s.red;
  assign bus.ew_yellow = ew_lamp_s.yellow;
  assign bus.ew_green  = ew_lamp_s.green;
  assign bus.walk      = walk_s;
  assign bus.ped_pend  = ped_pend_r;

  intersection_controller_chk u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .ns_lamp (ns_lamp_s),
    .ew_lamp (ew_lamp_s),
    .walk    (walk_s)
  );

endmodule
